// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Serial transmitter for 8N1 frames. Each frame is a start bit (0), eight data
// bits sent LSB first, and a stop bit (1). Every bit is held on the line for
// CLKS_PER_BIT clock cycles. The line idles high.
//
// The upstream buffer registers a new byte only while tx_busy is low. tx_busy
// is combinational and includes valid_in, so an upstream register stops issuing
// in the same cycle that it presents a byte. A byte offered while a frame is in
// progress is dropped, and overrun pulses for one cycle to report it.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2); 868 = 100 MHz / 115200
//
// Ports
//   clk       in   single clock; all state changes on its rising edge
//   rst       in   synchronous, active-high reset
//   valid_in  in   byte_in holds a byte offered for transmission
//   byte_in   in   byte to send; sampled only in the cycle it is accepted
//   tx        out  registered serial line, idle high
//   tx_busy   out  upstream must not issue a byte while this is high
//   overrun   out  one-cycle pulse after each cycle in which a byte was dropped
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       tx_busy,
    output logic       overrun
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               overrun_q, overrun_d;
    logic               bitEnd;

    // The last cycle of the current bit period. Every bit boundary, whatever
    // the state, is taken on this condition.
    assign bitEnd = (baud_q == BAUD_LAST);

    // State register. Reset returns the line to idle and clears every counter
    // and the shift register, so a frame that reset cuts short leaves nothing
    // behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic. tx is registered, so the next line level is chosen one
    // cycle ahead. On acceptance the start bit is loaded. At the end of the
    // start bit, and at the end of each of the first seven data bits, the next
    // data bit is taken from shift_q[0] and the register shifts right. This
    // keeps the bits LSB first.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        // A byte offered while a frame is in progress is dropped. The frame
        // continues unchanged, and the drop is reported in the next cycle.
        overrun_d = valid_in && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (valid_in) begin
                    shift_d = byte_in;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end

            START: begin
                if (bitEnd) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            DATA: begin
                if (bitEnd) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            STOP: begin
                if (bitEnd) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                baud_d  = '0;
            end
        endcase
    end

    // During reset the state term of tx_busy is masked. This stops a frame that
    // reset is about to abort from holding off upstream, so tx_busy follows
    // valid_in alone while rst is high.
    assign tx_busy = valid_in | ((state_q != IDLE) & ~rst);
    assign tx      = tx_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Self-checking bench for uart_tx with CLKS_PER_BIT = 4. A frame-level
// reference model predicts the outputs in every cycle. The model records when
// each byte was accepted and which byte it was. The line level in any cycle is
// then looked up from the 10-bit frame pattern. A small table of hand-computed
// vectors covers reset, overrun and abort. A serial decoder reads the recorded
// line and checks back-to-back traffic from a registered upstream.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam int NONE  = -1000000;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in;
    logic [7:0] byte_in;
    logic       tx;
    logic       tx_busy;
    logic       overrun;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .byte_in  (byte_in),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .overrun  (overrun)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: cycle of the last acceptance and the byte taken.
    int         acceptCycle = NONE;
    logic [7:0] frameByte   = 8'h00;
    logic       ovPending   = 1'b0;
    bit         modelOn     = 1'b0;

    // Line level recorded in every cycle. txLog[i] belongs to cycle i+1.
    logic txLog[$];
    logic [7:0] rxBytes[$];
    int         rxStarts[$];

    // Hand-computed vector: inputs for one cycle and the outputs expected in
    // that same cycle.
    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] b;
        logic       eTx;
        logic       eBusy;
        logic       eOvr;
    } vec_t;

    vec_t vecs[12];

    // Index 0 is the start bit, 1..8 are the data bits LSB first, and 9 is the
    // stop bit.
    function automatic logic frameBit(logic [7:0] b, int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, actual, expected);
        end
    endtask

    task automatic checkInt(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, sample at the falling edge, check against the
    // model, then advance the model with this cycle's inputs.
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] b);
        int   k;
        logic act;
        logic eTx;
        logic eBusy;
        @(posedge clk);
        #1;
        rst      = r;
        valid_in = v;
        byte_in  = b;
        @(negedge clk);
        cyc++;
        k     = cyc - acceptCycle - 1;
        act   = (k >= 0) && (k < FRAME);
        eTx   = act ? frameBit(frameByte, k / CPB) : 1'b1;
        eBusy = v | (act & ~r);
        txLog.push_back(tx);
        if (modelOn) begin
            checkOutput("tx", tx, eTx);
            checkOutput("tx_busy", tx_busy, eBusy);
            checkOutput("overrun", overrun, ovPending);
        end
        ovPending = v & act & ~r;
        if (r) begin
            acceptCycle = NONE;
        end else if (v && !act) begin
            acceptCycle = cyc;
            frameByte   = b;
        end
        if (r) modelOn = 1'b1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'($urandom));
    endtask

    // Decode 8N1 frames from txLog, starting at log index `from`. Each byte is
    // sampled in the middle of its bit period, and the stop bit must be high.
    task automatic decodeTx(input int from);
        int   i;
        logic [7:0] d;
        rxBytes.delete();
        rxStarts.delete();
        i = (from < 1) ? 1 : from;
        while (i + FRAME <= txLog.size()) begin
            if (txLog[i-1] === 1'b1 && txLog[i] === 1'b0) begin
                for (int j = 0; j < 8; j++) d[j] = txLog[i + CPB*(j+1) + CPB/2];
                checkOutput("rx_stop_bit", txLog[i + 9*CPB + CPB/2], 1'b1);
                rxBytes.push_back(d);
                rxStarts.push_back(i);
                i += FRAME;
            end else begin
                i++;
            end
        end
    endtask

    initial begin
        logic [7:0] upQ[$];
        logic       upV;
        logic [7:0] upB;
        int         upIdx;
        int         logStart;

        rst      = 1'b1;
        valid_in = 1'b0;
        byte_in  = 8'h00;

        // Reset, then the reset state with valid_in both low and high.
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("reset_tx", tx, 1'b1);
        checkOutput("reset_overrun", overrun, 1'b0);
        checkOutput("reset_busy_follows_valid", tx_busy, 1'b0);

        // Vectors were computed by hand from the frame timing. The row index
        // is counted from the first row, and the 0xA5 acceptance is row 2.
        vecs[0]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'h81, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].r, vecs[i].v, vecs[i].b);
            checkOutput($sformatf("vec%0d_tx", i), tx, vecs[i].eTx);
            checkOutput($sformatf("vec%0d_busy", i), tx_busy, vecs[i].eBusy);
            checkOutput($sformatf("vec%0d_overrun", i), overrun, vecs[i].eOvr);
        end
        idleCycles(FRAME + 4);

        // 0xA5 frame. 0x3C is offered at A+10 and is dropped.
        logStart = txLog.size();
        applyStimulus(1'b0, 1'b1, 8'hA5);
        idleCycles(9);
        applyStimulus(1'b0, 1'b1, 8'h3C);
        idleCycles(FRAME + 4);
        decodeTx(logStart);
        checkInt("a5_frame_count", rxBytes.size(), 1);
        if (rxBytes.size() > 0) checkInt("a5_frame_data", int'(rxBytes[0]), 'hA5);

        // Reset at A+20 aborts the frame. 0x81 offered at A+22 is sent in full.
        applyStimulus(1'b0, 1'b1, 8'hC3);
        idleCycles(19);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("abort_tx_high", tx, 1'b1);
        checkOutput("abort_not_busy", tx_busy, 1'b0);
        logStart = txLog.size();
        applyStimulus(1'b0, 1'b1, 8'h81);
        idleCycles(FRAME + 4);
        decodeTx(logStart);
        checkInt("after_abort_count", rxBytes.size(), 1);
        if (rxBytes.size() > 0) checkInt("after_abort_data", int'(rxBytes[0]), 'h81);

        // After acceptance of 0x5A, byte_in changes every cycle.
        logStart = txLog.size();
        applyStimulus(1'b0, 1'b1, 8'h5A);
        idleCycles(FRAME + 4);
        decodeTx(logStart);
        checkInt("toggle_count", rxBytes.size(), 1);
        if (rxBytes.size() > 0) checkInt("toggle_data", int'(rxBytes[0]), 'h5A);

        // Registered upstream that issues on !tx_busy. Frames must follow each
        // other every 42 cycles, with no byte lost or repeated.
        upQ = '{8'h00, 8'hFF, 8'($urandom), 8'($urandom), 8'($urandom)};
        upV = 1'b0;
        upB = 8'h00;
        upIdx = 0;
        logStart = txLog.size();
        for (int c = 0; c < upQ.size() * 50 + 60; c++) begin
            applyStimulus(1'b0, upV, upB);
            if (!tx_busy && upIdx < upQ.size()) begin
                upV = 1'b1;
                upB = upQ[upIdx];
                upIdx++;
            end else begin
                upV = 1'b0;
                upB = 8'($urandom);
            end
        end
        decodeTx(logStart);
        checkInt("upstream_frame_count", rxBytes.size(), upQ.size());
        for (int i = 0; i < upQ.size() && i < rxBytes.size(); i++)
            checkInt($sformatf("upstream_byte%0d", i), int'(rxBytes[i]), int'(upQ[i]));
        for (int i = 1; i < rxStarts.size(); i++)
            checkInt($sformatf("upstream_spacing%0d", i), rxStarts[i] - rxStarts[i-1], FRAME + 2);

        // Random traffic with occasional resets, checked cycle by cycle.
        for (int c = 0; c < 2500; c++) begin
            applyStimulus(($urandom_range(0, 299) == 0),
                          ($urandom_range(0, 9) == 0),
                          8'($urandom));
        end
        idleCycles(FRAME + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog: the stimulus above is bounded, so this only fires on a hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog cycle %0d: got timeout expected completion", cyc);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SHALL set clock cycles per serial bit (100 MHz / 115200 baud); legal range >= 2.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 valid_in  input  1  SHALL mark byte_in as a byte offered for transmission.
REQ-005 byte_in  input  8  SHALL carry the byte to transmit; sampled only on acceptance.
REQ-006 tx  output  1  SHALL be the serial line: idle high, 8N1 framing.
REQ-007 tx_busy  output  1  SHALL tell the upstream buffer not to issue a byte.
REQ-008 overrun  output  1  SHALL pulse when an offered byte is dropped.

Function
REQ-009 FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-010 Acceptance SHALL occur in any cycle with state==IDLE and valid_in==1: byte_in latched into shift register; state<=START.
REQ-011 tx_busy SHALL be combinational: (state!=IDLE) OR valid_in, so that a registered upstream stops issuing in the same cycle a byte is presented.
REQ-012 tx SHALL be registered; on acceptance in cycle A, tx SHALL be 0 for cycles A+1..A+CLKS_PER_BIT (start bit).
REQ-013 DATA SHALL shift out 8 bits LSB first, each held exactly CLKS_PER_BIT cycles, tracked by a 3-bit bit counter.
REQ-014 STOP SHALL drive tx=1 for exactly CLKS_PER_BIT cycles, then return to IDLE with tx remaining 1.
REQ-015 A baud counter of width $clog2(CLKS_PER_BIT) SHALL count 0..CLKS_PER_BIT-1 per bit and clear on every bit boundary and on acceptance.
REQ-016 Frame SHALL occupy cycles A+1..A+10*CLKS_PER_BIT; state SHALL be IDLE in cycle A+10*CLKS_PER_BIT+1.
REQ-017 Minimum spacing between acceptances SHALL be 10*CLKS_PER_BIT+1 cycles; no byte SHALL be accepted while state!=IDLE.
REQ-018 valid_in==1 while state!=IDLE SHALL leave the frame in progress unaltered, drop the byte, and set overrun=1 for exactly the next cycle.
REQ-019 overrun SHALL be 0 in all other cycles; repeated dropped offers SHALL produce one pulse per offering cycle.
REQ-020 Changes on byte_in after acceptance SHALL NOT affect the frame.
REQ-021 With the upstream buffer registering on !tx_busy, back-to-back bytes SHALL be transmitted with no loss and no duplication.

Reset
REQ-022 rst==1 at a clock edge SHALL force state=IDLE, tx=1, overrun=0, and clear the bit counter, baud counter, and shift register; these values SHALL be visible the following cycle.
REQ-023 rst SHALL take priority over acceptance: valid_in asserted in a reset cycle SHALL NOT start a frame.
REQ-024 Reset mid-frame SHALL abort the frame; tx SHALL return to 1 the next cycle, and tx_busy SHALL equal valid_in from that cycle.
REQ-025 tx_busy SHALL follow valid_in during reset (combinational term); state contribution SHALL be 0.

Verification (CLKS_PER_BIT=4)
REQ-026 Scenario: single byte 0xA5 accepted at cycle A -> tx reads 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles over A+1..A+40; tx_busy high A..A+40; IDLE at A+41.
REQ-027 Scenario: 0x00 then 0xFF via a registered upstream that issues on !tx_busy -> two complete frames, second start bit begins 42 cycles after the first; tx reads 0x00 data bits as 0 and 0xFF data bits as 1; no overrun.
REQ-028 Scenario: valid_in with 0x3C pulsed at cycle A+10 during the 0xA5 frame -> 0xA5 frame bit-exact, overrun=1 at A+11 only, 0x3C never transmitted.
REQ-029 Scenario: rst asserted at cycle A+20 of a frame -> tx=1, state IDLE at A+21; a new byte 0x81 offered at A+22 transmits correctly.
REQ-030 Scenario: rst and valid_in both high in one cycle -> no start bit, tx stays 1, overrun stays 0.
REQ-031 Scenario: byte_in toggled every cycle after acceptance of 0x5A -> transmitted data equals 0x5A.
